// File: rtl/mult_seq_ctrl_if.sv
// Operand/result bundle for the sequential multiplier.
// The requester drives start/a/b; the multiplier returns busy/done/product.
interface mult_seq_ctrl_if #(parameter int WIDTH = 4);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add multiplier: one multiplier bit per cycle through a single (WIDTH+1)-bit
// ripple adder. Optional early termination when MULT_SEQ_EARLY_TERM_EN is defined.
module mult_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_full;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_early;
  logic               w_last;

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // Ripple chain: half adder on bit 0, full adders above, carry-out becomes bit WIDTH.
  always_comb begin
    logic [1:0] cs;
    w_sum    = '0;
    w_addend = r_mplier[0] ? r_mcand : '0;
    cs       = ha(r_acc[0], w_addend[0]);
    w_sum[0] = cs[0];
    for (int i = 1; i < WIDTH; i++) begin
      cs       = fa(r_acc[i], w_addend[i], cs[1]);
      w_sum[i] = cs[0];
    end
    w_sum[WIDTH] = cs[1];
  end

  // {carry, acc, mplier} after this cycle's right shift, as one 2*WIDTH word
  assign w_full = {w_sum, r_mplier[WIDTH-1:1]};

`ifdef MULT_SEQ_EARLY_TERM_EN
  logic [WIDTH-1:0] w_mask;
  logic [CW-1:0]    w_rem;
  assign w_rem = CW'(WIDTH-1) - r_cnt;
  // Bits 1..WIDTH-1-cnt of mplier are original multiplier bits still to be consumed.
  always_comb begin
    w_mask = '0;
    for (int j = 1; j < WIDTH; j++)
      w_mask[j] = (j <= (WIDTH - 1 - int'(r_cnt)));
  end
  assign w_early    = ~|(r_mplier & w_mask);
  assign w_prod_nxt = w_full >> w_rem;
`else
  assign w_early    = 1'b0;
  assign w_prod_nxt = w_full;
`endif

  assign w_last = (r_cnt == CW'(WIDTH-1)) || w_early;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc    <= w_sum[WIDTH:1];
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_product <= w_prod_nxt;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule
